// File: rtl/morse_2_ascii.sv
// Morse key decoder: times marks and gaps on a synchronized key level,
// collects dot/dash elements and emits the ASCII character (or a space).
module morse_2_ascii #(
  parameter int UNIT_CYCLES = 1200000
) (
  input  logic       clk_24,
  input  logic       rst_n,
  input  logic       key_in,
  output logic [6:0] ascii_code,
  output logic       ascii_valid,
  output logic       code_err,
  output logic       busy,
  output logic [1:0] fsm_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MARK = 2'd1,
    GAP  = 2'd2,
    LGAP = 2'd3
  } state_t;

  // cnt is cleared on entry to MARK/GAP, so a count of N means N+1 cycles
  // of mark (or of silence) have been seen; thresholds are one below.
  localparam logic [23:0] CNT_MAX  = 24'(7 * UNIT_CYCLES);
  localparam logic [23:0] DASH_CNT = 24'(2 * UNIT_CYCLES - 1);
  localparam logic [23:0] CHAR_CNT = 24'(2 * UNIT_CYCLES - 1);
  localparam logic [23:0] WORD_CNT = 24'(5 * UNIT_CYCLES - 1);

  state_t      state;
  logic        key_m;
  logic        key_s;
  logic [23:0] cnt;
  logic [6:0]  code;
  logic [2:0]  len;
  logic        ovf;
  logic [6:0]  code_app;
  logic        dash_now;
  logic [7:0]  lookup;

  // Returns {hit, ascii}; element i of the character sits in code bit i.
  function automatic logic [7:0] morse_lookup(input logic [2:0] n, input logic [6:0] c);
    logic [9:0] k;
    k = {n, c};
    case (k)
      {3'd2, 7'b0000010}: morse_lookup = {1'b1, 7'd65};  // A
      {3'd4, 7'b0000001}: morse_lookup = {1'b1, 7'd66};  // B
      {3'd4, 7'b0000101}: morse_lookup = {1'b1, 7'd67};  // C
      {3'd3, 7'b0000001}: morse_lookup = {1'b1, 7'd68};  // D
      {3'd1, 7'b0000000}: morse_lookup = {1'b1, 7'd69};  // E
      {3'd4, 7'b0000100}: morse_lookup = {1'b1, 7'd70};  // F
      {3'd3, 7'b0000011}: morse_lookup = {1'b1, 7'd71};  // G
      {3'd4, 7'b0000000}: morse_lookup = {1'b1, 7'd72};  // H
      {3'd2, 7'b0000000}: morse_lookup = {1'b1, 7'd73};  // I
      {3'd4, 7'b0001110}: morse_lookup = {1'b1, 7'd74};  // J
      {3'd3, 7'b0000101}: morse_lookup = {1'b1, 7'd75};  // K
      {3'd4, 7'b0000010}: morse_lookup = {1'b1, 7'd76};  // L
      {3'd2, 7'b0000011}: morse_lookup = {1'b1, 7'd77};  // M
      {3'd2, 7'b0000001}: morse_lookup = {1'b1, 7'd78};  // N
      {3'd3, 7'b0000111}: morse_lookup = {1'b1, 7'd79};  // O
      {3'd4, 7'b0000110}: morse_lookup = {1'b1, 7'd80};  // P
      {3'd4, 7'b0001011}: morse_lookup = {1'b1, 7'd81};  // Q
      {3'd3, 7'b0000010}: morse_lookup = {1'b1, 7'd82};  // R
      {3'd3, 7'b0000000}: morse_lookup = {1'b1, 7'd83};  // S
      {3'd1, 7'b0000001}: morse_lookup = {1'b1, 7'd84};  // T
      {3'd3, 7'b0000100}: morse_lookup = {1'b1, 7'd85};  // U
      {3'd4, 7'b0001000}: morse_lookup = {1'b1, 7'd86};  // V
      {3'd3, 7'b0000110}: morse_lookup = {1'b1, 7'd87};  // W
      {3'd4, 7'b0001001}: morse_lookup = {1'b1, 7'd88};  // X
      {3'd4, 7'b0001101}: morse_lookup = {1'b1, 7'd89};  // Y
      {3'd4, 7'b0000011}: morse_lookup = {1'b1, 7'd90};  // Z
      {3'd5, 7'b0011111}: morse_lookup = {1'b1, 7'd48};  // 0
      {3'd5, 7'b0011110}: morse_lookup = {1'b1, 7'd49};  // 1
      {3'd5, 7'b0011100}: morse_lookup = {1'b1, 7'd50};  // 2
      {3'd5, 7'b0011000}: morse_lookup = {1'b1, 7'd51};  // 3
      {3'd5, 7'b0010000}: morse_lookup = {1'b1, 7'd52};  // 4
      {3'd5, 7'b0000000}: morse_lookup = {1'b1, 7'd53};  // 5
      {3'd5, 7'b0000001}: morse_lookup = {1'b1, 7'd54};  // 6
      {3'd5, 7'b0000011}: morse_lookup = {1'b1, 7'd55};  // 7
      {3'd5, 7'b0000111}: morse_lookup = {1'b1, 7'd56};  // 8
      {3'd5, 7'b0001111}: morse_lookup = {1'b1, 7'd57};  // 9
      {3'd6, 7'b0110101}: morse_lookup = {1'b1, 7'd33};  // !
      {3'd6, 7'b0010010}: morse_lookup = {1'b1, 7'd34};  // "
      {3'd7, 7'b1001000}: morse_lookup = {1'b1, 7'd36};  // $
      {3'd5, 7'b0000010}: morse_lookup = {1'b1, 7'd38};  // &
      {3'd6, 7'b0011110}: morse_lookup = {1'b1, 7'd39};  // '
      {3'd5, 7'b0001101}: morse_lookup = {1'b1, 7'd40};  // (
      {3'd6, 7'b0101101}: morse_lookup = {1'b1, 7'd41};  // )
      {3'd5, 7'b0001010}: morse_lookup = {1'b1, 7'd43};  // +
      {3'd6, 7'b0110011}: morse_lookup = {1'b1, 7'd44};  // ,
      {3'd6, 7'b0100001}: morse_lookup = {1'b1, 7'd45};  // -
      {3'd6, 7'b0101010}: morse_lookup = {1'b1, 7'd46};  // .
      {3'd5, 7'b0001001}: morse_lookup = {1'b1, 7'd47};  // /
      {3'd6, 7'b0000111}: morse_lookup = {1'b1, 7'd58};  // :
      {3'd6, 7'b0010101}: morse_lookup = {1'b1, 7'd59};  // ;
      {3'd5, 7'b0010001}: morse_lookup = {1'b1, 7'd61};  // =
      {3'd6, 7'b0001100}: morse_lookup = {1'b1, 7'd63};  // ?
      {3'd6, 7'b0010110}: morse_lookup = {1'b1, 7'd64};  // @
      {3'd6, 7'b0101100}: morse_lookup = {1'b1, 7'd95};  // _
      default:            morse_lookup = 8'd0;
    endcase
  endfunction

  assign dash_now = (cnt >= DASH_CNT);
  assign lookup   = morse_lookup(len, code);

  always_comb begin
    code_app = code;
    for (int i = 0; i < 7; i++) begin
      if (3'(i) == len) code_app[i] = dash_now;
    end
  end

  // ascii_valid / code_err are single-cycle pulses with no back-pressure;
  // ascii_code is meaningful only while ascii_valid is high and holds otherwise.
  always_ff @(posedge clk_24 or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      key_m       <= 1'b0;
      key_s       <= 1'b0;
      cnt         <= 24'd0;
      code        <= 7'd0;
      len         <= 3'd0;
      ovf         <= 1'b0;
      ascii_code  <= 7'd0;
      ascii_valid <= 1'b0;
      code_err    <= 1'b0;
    end else begin
      key_m       <= key_in;
      key_s       <= key_m;
      ascii_valid <= 1'b0;
      code_err    <= 1'b0;
      if (cnt < CNT_MAX) cnt <= cnt + 24'd1;

      case (state)
        IDLE: begin
          code <= 7'd0;
          len  <= 3'd0;
          ovf  <= 1'b0;
          if (key_s) begin
            state <= MARK;
            cnt   <= 24'd0;
          end
        end

        MARK: begin
          if (!key_s) begin
            if (len == 3'd7) begin
              ovf <= 1'b1;
            end else begin
              code <= code_app;
              len  <= len + 3'd1;
            end
            state <= GAP;
            cnt   <= 24'd0;
          end
        end

        // Reaching the threshold wins over a key press on the same cycle.
        GAP: begin
          if (cnt >= CHAR_CNT) begin
            if (!ovf && lookup[7]) begin
              ascii_valid <= 1'b1;
              ascii_code  <= lookup[6:0];
            end else begin
              code_err <= 1'b1;
            end
            code  <= 7'd0;
            len   <= 3'd0;
            ovf   <= 1'b0;
            state <= LGAP;
          end else if (key_s) begin
            state <= MARK;
            cnt   <= 24'd0;
          end
        end

        LGAP: begin
          if (cnt >= WORD_CNT) begin
            ascii_valid <= 1'b1;
            ascii_code  <= 7'd32;
            state       <= IDLE;
          end else if (key_s) begin
            state <= MARK;
            cnt   <= 24'd0;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign busy      = (state != IDLE);
  assign fsm_state = state;

endmodule
